// File: rtl/alu32_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, job layout and
// the mask priority helpers used to walk a job's enabled opcodes.
package alu32_pkg;

  localparam int ALU_W  = 32;
  localparam int OP_W   = 3;
  localparam int MASK_W = 8;
  localparam int JOB_W  = 2 * ALU_W + 1 + MASK_W;

  localparam logic [OP_W-1:0] OP_AND    = 3'd0;
  localparam logic [OP_W-1:0] OP_OR     = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
  localparam logic [OP_W-1:0] OP_NOT    = 3'd3;
  localparam logic [OP_W-1:0] OP_ADD    = 3'd4;
  localparam logic [OP_W-1:0] OP_LSHIFT = 3'd5;
  localparam logic [OP_W-1:0] OP_RSHIFT = 3'd6;
  localparam logic [OP_W-1:0] OP_TRUNC  = 3'd7;

  typedef struct packed {
    logic [ALU_W-1:0]  a;
    logic [ALU_W-1:0]  b;
    logic              ci;
    logic [MASK_W-1:0] mask;
  } JobFields;

  typedef enum logic {IDLE, ISSUE} SeqState;

  // An empty mask means "run every opcode".
  function automatic logic [MASK_W-1:0] effMask(input logic [MASK_W-1:0] m);
    return (m == '0) ? '1 : m;
  endfunction

  function automatic logic [OP_W-1:0] lowestBit(input logic [MASK_W-1:0] m);
    logic [OP_W-1:0] idx;
    idx = '0;
    for (int k = MASK_W - 1; k >= 0; k--)
      if (m[k]) idx = OP_W'(k);
    return idx;
  endfunction

  // Returns {found, index} of the lowest set bit strictly above cur.
  function automatic logic [OP_W:0] nextBit(input logic [MASK_W-1:0] m,
                                            input logic [OP_W-1:0]   cur);
    logic [OP_W:0] res;
    res = '0;
    for (int k = MASK_W - 1; k >= 0; k--)
      if (m[k] && (k > int'(cur))) res = {1'b1, OP_W'(k)};
    return res;
  endfunction

endpackage

// File: rtl/alu32_job_fifo.sv
// Job buffer for the issue sequencer. Exposes both the head entry and the
// entry behind it so the sequencer can preload the following job's opcode.
module alu32_job_fifo
  import alu32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = JOB_W
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       headData,
  output logic [WIDTH-1:0]       nextData,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic             doPush;
  logic             doPop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign headData = mem[rdPtr];
  assign nextData = mem[rdPtr + PW'(1)];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/alu32_issue_seq.sv
// Issue sequencer: walks each buffered job through its enabled ALU opcodes
// in ascending order and registers every ALU answer into a result stream.
module alu32_issue_seq
  import alu32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ALU_W
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         In_Valid,
  output logic         In_Ready,
  input  logic [W-1:0] In_A,
  input  logic [W-1:0] In_B,
  input  logic         In_CI,
  input  logic [7:0]   In_Mask,
  output logic [W-1:0] AluIn1,
  output logic [W-1:0] AluIn2,
  output logic         AluCI,
  output logic [2:0]   AluA,
  input  logic [W-1:0] AluOut,
  input  logic         AluCO,
  output logic         Res_Valid,
  input  logic         Res_Ready,
  output logic [W-1:0] Res_Data,
  output logic         Res_CO,
  output logic [2:0]   Res_Op,
  output logic         Res_Last,
  output logic         Busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  JobFields          pushJob;
  JobFields          headJob;
  JobFields          nextJob;
  logic [JOB_W-1:0]  headRaw;
  logic [JOB_W-1:0]  nextRaw;
  logic [CW-1:0]     fifoCount;
  logic              fifoFull;
  logic              fifoEmpty;
  SeqState           state;
  logic [OP_W-1:0]   opCnt;
  logic [OP_W:0]     nextInfo;
  logic              lastOp;
  logic              capture;
  logic              pushFire;
  logic              popJob;
  logic              followAvail;
  logic [MASK_W-1:0] followMask;

  assign pushJob = '{a: In_A, b: In_B, ci: In_CI, mask: effMask(In_Mask)};
  assign headJob = headRaw;
  assign nextJob = nextRaw;

  assign In_Ready = !fifoFull;
  assign pushFire = In_Valid && !fifoFull;
  assign nextInfo = nextBit(headJob.mask, opCnt);
  assign lastOp   = !nextInfo[OP_W];
  assign capture  = (state == ISSUE) && !fifoEmpty && (!Res_Valid || Res_Ready);
  assign popJob   = capture && lastOp;

  // The job after the head is either already queued or arriving this very edge.
  assign followAvail = (fifoCount > CW'(1)) || pushFire;
  assign followMask  = (fifoCount > CW'(1)) ? nextJob.mask : pushJob.mask;

  assign AluIn1 = fifoEmpty ? '0 : headJob.a;
  assign AluIn2 = fifoEmpty ? '0 : headJob.b;
  assign AluCI  = fifoEmpty ? 1'b0 : headJob.ci;
  assign AluA   = fifoEmpty ? '0 : opCnt;
  assign Busy   = !fifoEmpty || Res_Valid;

  alu32_job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (JOB_W)
  ) jobFifo (
    .clock    (CLK),
    .resetN   (RST_N),
    .push     (pushFire),
    .pushData (pushJob),
    .pop      (popJob),
    .headData (headRaw),
    .nextData (nextRaw),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      opCnt     <= '0;
      Res_Valid <= 1'b0;
      Res_Data  <= '0;
      Res_CO    <= 1'b0;
      Res_Op    <= '0;
      Res_Last  <= 1'b0;
    end else begin
      if (capture) begin
        Res_Valid <= 1'b1;
        Res_Data  <= AluOut;
        Res_CO    <= AluCO;
        Res_Op    <= opCnt;
        Res_Last  <= lastOp;
      end else if (Res_Ready) begin
        Res_Valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Preloading on the push edge lets the first result appear one edge later.
          if (!fifoEmpty) begin
            opCnt <= lowestBit(headJob.mask);
            state <= ISSUE;
          end else if (pushFire) begin
            opCnt <= lowestBit(pushJob.mask);
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (capture) begin
            if (!lastOp) begin
              opCnt <= nextInfo[OP_W-1:0];
            end else if (followAvail) begin
              opCnt <= lowestBit(followMask);
            end else begin
              opCnt <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_issue_seq.sv
// Randomised bench for alu32_issue_seq with a behavioural ALU stand-in and a
// job-level reference model that expands each accepted job into its results.
module tb_alu32_issue_seq;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        In_Valid, In_Ready, In_CI, AluCI, AluCO;
  logic [31:0] In_A, In_B, AluIn1, AluIn2, AluOut, Res_Data;
  logic [7:0]  In_Mask;
  logic [2:0]  AluA, Res_Op;
  logic        Res_Valid, Res_Ready, Res_CO, Res_Last, Busy;

  typedef struct {
    logic [31:0] data;
    logic        co;
    logic [2:0]  op;
    logic        last;
  } ResItem;

  ResItem expQ[$];
  ResItem logQ[$];
  int     total = 0;
  int     bad = 0;
  int     readyMode = 1;
  int     expectedCount = 0;
  int     seenCount = 0;

  always #5 CLK = ~CLK;

  alu32_issue_seq #(.DEPTH(4), .W(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_A(In_A), .In_B(In_B),
    .In_CI(In_CI), .In_Mask(In_Mask),
    .AluIn1(AluIn1), .AluIn2(AluIn2), .AluCI(AluCI), .AluA(AluA),
    .AluOut(AluOut), .AluCO(AluCO),
    .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Res_Data(Res_Data),
    .Res_CO(Res_CO), .Res_Op(Res_Op), .Res_Last(Res_Last), .Busy(Busy)
  );

  // Stand-in for the combinational ALU that sits beside the sequencer.
  function automatic logic [32:0] aluModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic ci);
    case (op)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, a ^ b};
      3'd3:    return {1'b0, ~a};
      3'd4:    return {1'b0, a} + {1'b0, b} + {32'b0, ci};
      3'd5:    return {a[31], a << 1};
      3'd6:    return {a[0], a >> 1};
      default: return {1'b0, a & 32'h0000FFFF};
    endcase
  endfunction

  assign {AluCO, AluOut} = aluModel(AluA, AluIn1, AluIn2, AluCI);

  function automatic logic [63:0] packItem(input ResItem r);
    return {27'b0, r.last, r.op, r.co, r.data};
  endfunction

  function automatic void modelJob(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic [7:0] mask);
    logic [7:0]  m;
    logic [32:0] r;
    ResItem      item;
    m = (mask == 8'h00) ? 8'hFF : mask;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        r         = aluModel(3'(k), a, b, ci);
        item.data = r[31:0];
        item.co   = r[32];
        item.op   = 3'(k);
        item.last = ((m >> (k + 1)) == 8'h00);
        expQ.push_back(item);
        expectedCount++;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Handshakes are settled by the falling edge, so both streams are scored here.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (In_Valid && In_Ready) modelJob(In_A, In_B, In_CI, In_Mask);
      if (Res_Valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious", {27'b0, Res_Last, Res_Op, Res_CO, Res_Data}, 64'hDEAD);
        end else begin
          checkOutput("result", {27'b0, Res_Last, Res_Op, Res_CO, Res_Data}, packItem(expQ[0]));
          if (Res_Ready) begin
            logQ.push_back(expQ.pop_front());
            seenCount++;
          end
        end
      end
    end
  end

  initial begin
    Res_Ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (readyMode)
        0:       Res_Ready = 1'b0;
        1:       Res_Ready = 1'b1;
        default: Res_Ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic ci, input logic [7:0] mask);
    bit accepted = 0;
    In_Valid = 1'b1;
    In_A = a;
    In_B = b;
    In_CI = ci;
    In_Mask = mask;
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      if (In_Ready) begin
        accepted = 1;
        break;
      end
    end
    @(posedge CLK);
    #1;
    In_Valid = 1'b0;
    if (!accepted) checkOutput("pushTimeout", 64'(accepted), 64'd1);
  endtask

  task automatic waitDrain(input int bound);
    bit drained = 0;
    for (int t = 0; t < bound; t++) begin
      @(negedge CLK);
      if (expQ.size() == 0 && !Busy) begin
        drained = 1;
        break;
      end
    end
    checkOutput("drained", 64'(drained), 64'd1);
    checkOutput("leftover", 64'(expQ.size()), 64'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] t1Data [5];
    bit          found;
    t1Data = '{32'h3, 32'hF, 32'hC, 32'hFFFFFFF0, 32'h12};
    In_Valid = 0; In_A = 0; In_B = 0; In_CI = 0; In_Mask = 0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rstInReady", 64'(In_Ready), 64'd1);
    checkOutput("rstResValid", 64'(Res_Valid), 64'd0);
    checkOutput("rstBusy", 64'(Busy), 64'd0);
    checkOutput("rstDrive", {AluA, AluCI, AluIn1, AluIn2[27:0]}, 64'd0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] directed mask 0x1F job");
    logQ.delete();
    applyStimulus(32'h0000000F, 32'h00000003, 1'b0, 8'h1F);
    waitDrain(100);
    checkOutput("t1Count", 64'(logQ.size()), 64'd5);
    for (int i = 0; i < 5 && i < logQ.size(); i++) begin
      checkOutput("t1Data", 64'(logQ[i].data), 64'(t1Data[i]));
      checkOutput("t1OpLast", {logQ[i].op, logQ[i].last}, {3'(i), (i == 4)});
    end

    $display("[TB] directed single ADD job with latency");
    logQ.delete();
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b1, 8'h10);
    @(negedge CLK);
    checkOutput("latencyEarly", 64'(Res_Valid), 64'd0);
    @(negedge CLK);
    checkOutput("latencyOnTime", 64'(Res_Valid), 64'd1);
    @(posedge CLK);
    #1;
    waitDrain(100);
    checkOutput("t2Count", 64'(logQ.size()), 64'd1);
    if (logQ.size() > 0)
      checkOutput("t2Result", {logQ[0].last, logQ[0].op, logQ[0].co, logQ[0].data},
                  {1'b1, 3'd4, 1'b1, 32'h00000001});

    $display("[TB] empty mask sweeps all opcodes");
    logQ.delete();
    applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 8'h00);
    waitDrain(100);
    checkOutput("t3Count", 64'(logQ.size()), 64'd8);
    for (int i = 0; i < 8 && i < logQ.size(); i++)
      checkOutput("t3Op", 64'(logQ[i].op), 64'(i));

    $display("[TB] back-pressure with full buffer");
    readyMode = 0;
    repeat (2) @(posedge CLK);
    #1;
    for (int j = 0; j < 4; j++)
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 8'($urandom) | 8'h03);
    @(negedge CLK);
    checkOutput("fullReady", 64'(In_Ready), 64'd0);
    @(posedge CLK);
    #1;
    fork
      applyStimulus($urandom, $urandom, 1'b0, 8'($urandom));
      begin
        repeat (4) begin
          @(negedge CLK);
          checkOutput("stallHold", {In_Ready, Res_Valid, Res_Op}, {1'b0, 1'b1, 3'd0});
        end
        readyMode = 1;
      end
    join
    waitDrain(300);

    $display("[TB] random back-pressure over many jobs");
    readyMode = 2;
    for (int j = 0; j < 1000; j++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK);
        #1;
      end
    end
    waitDrain(2000);
    readyMode = 1;
    checkOutput("resultTotal", 64'(seenCount), 64'(expectedCount));

    $display("[TB] reset in the middle of a job");
    repeat (2) @(posedge CLK);
    #1;
    applyStimulus($urandom, $urandom, 1'b0, 8'hFF);
    found = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge CLK);
      if (AluA == 3'd3) begin
        found = 1;
        break;
      end
    end
    checkOutput("reachOp3", 64'(found), 64'd1);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("midRstReady", {In_Ready, Res_Valid, Busy}, {1'b1, 1'b0, 1'b0});
    checkOutput("midRstDrive", {AluA, AluCI, AluIn1, AluIn2[27:0]}, 64'd0);
    checkOutput("midRstRes", {27'b0, Res_Last, Res_Op, Res_CO, Res_Data}, 64'd0);
    expQ.delete();
    logQ.delete();
    expectedCount = 0;
    seenCount = 0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    applyStimulus($urandom, $urandom, 1'b1, 8'h30);
    waitDrain(100);
    checkOutput("restartCount", 64'(logQ.size()), 64'd2);
    if (logQ.size() == 2)
      checkOutput("restartOps", {logQ[0].op, logQ[0].last, logQ[1].op, logQ[1].last},
                  {3'd4, 1'b0, 3'd5, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
